ysyx_bus_arb: RTL and testbench
===============================

YSYX_BUS_ARB -- requirements
Module: ysyx_bus_arb

Interface
REQ-001 SHALL have parameter BIT_W, default 32: width of address and data.
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ifu_araddr  in  BIT_W  instruction fetch address
- ifu_arvalid  in  1  fetch request, level-held until ifu_rvalid
- ifu_rdata  out  BIT_W  fetch data
- ifu_rvalid  out  1  fetch response pulse
- lsu_araddr  in  BIT_W  load address
- lsu_arvalid  in  1  load request, level-held until lsu_rvalid
- lsu_rstrb  in  8  load byte strobe
- lsu_rdata  out  BIT_W  load data
- lsu_rvalid  out  1  load response pulse
- lsu_awaddr  in  BIT_W  store address
- lsu_awvalid  in  1  store address valid
- lsu_wdata  in  BIT_W  store data
- lsu_wstrb  in  8  store byte strobe
- lsu_wvalid  in  1  store data valid, held with lsu_awvalid until lsu_wready
- lsu_wready  out  1  store completion pulse
- mem_araddr  out  BIT_W  memory read address
- mem_arvalid  out  1  memory read request
- mem_rstrb  out  8  memory read strobe
- mem_arready  in  1  memory accepts read address
- mem_rdata  in  BIT_W  memory read data
- mem_rvalid  in  1  memory read data valid
- mem_awaddr  out  BIT_W  memory write address
- mem_awvalid  out  1  memory write address valid
- mem_wdata  out  BIT_W  memory write data
- mem_wstrb  out  8  memory write strobe
- mem_wvalid  out  1  memory write data valid
- mem_wready  in  1  memory write complete

Function
REQ-003 SHALL implement FSM states IDLE, RD_AR, RD_R, WR, RESP. Exactly one transaction SHALL be outstanding.
REQ-004 In IDLE, a store request is pending when lsu_awvalid&lsu_wvalid, a load request when lsu_arvalid, and a fetch request when ifu_arvalid.
REQ-005 Within LSU, store SHALL win over load. LSU vs IFU SHALL be round-robin: if both are pending, grant the requester not granted last. The last-grant flag resets to IFU, so LSU wins the first tie.
REQ-006 On grant, SHALL register owner, address, strobe and (for a store) wdata. A store goes to WR; a read goes to RD_AR.
REQ-007 RD_AR: mem_arvalid=1 with the registered address and rstrb. On mem_arready, go to RD_R.
REQ-008 RD_R: mem_arvalid=0. On mem_rvalid, capture mem_rdata into a data register and go to RESP. mem_rvalid outside RD_R SHALL be ignored.
REQ-009 WR: mem_awvalid=mem_wvalid=1 with the registered address, data and strobe. On mem_wready, go to RESP.
REQ-010 RESP (1 cycle): assert exactly one of ifu_rvalid, lsu_rvalid or lsu_wready for the owner, with the matching rdata from the data register. Then go to IDLE unconditionally.
REQ-011 ifu_rdata/lsu_rdata SHALL hold the last captured data. rvalid/wready SHALL be 0 outside RESP.
REQ-012 Latency: request seen in IDLE at cycle 0 gives mem_arvalid at cycle 1. mem_rvalid at cycle k gives requester rvalid at cycle k+1. Minimum read takes 4 cycles when mem_arready=1 at cycle 1 and mem_rvalid=1 at cycle 2.
REQ-013 Requester valid dropped mid-transaction SHALL NOT abort it; the response is still pulsed.
REQ-014 The cycle after RESP is IDLE. Requesters deasserting on the RESP edge SHALL NOT be re-granted.

Reset
REQ-015 rst SHALL force IDLE, last-grant=IFU, and all mem_*valid, ifu_rvalid, lsu_rvalid, lsu_wready=0, data register=0 on the next edge.
REQ-016 rst mid-transaction SHALL drop the transaction with no response pulse. Late mem_rvalid/mem_wready SHALL be ignored in IDLE.

Verification
REQ-017 Fetch 0x80000000, mem_arready=1 at c1, mem_rvalid=1 with rdata=0x00000413 at c2 -> ifu_rvalid=1, ifu_rdata=0x00000413 at c3 only.
REQ-018 ifu_arvalid and lsu_arvalid both asserted after reset -> LSU served first. IFU is served in the next IDLE, with mem_araddr switching accordingly.
REQ-019 Store: lsu_awaddr=0xa00003f8, wdata=0x41, wstrb=0x1, with lsu_arvalid also high -> WR with mem_wstrb=0x01. mem_wready at c3 -> lsu_wready at c4, then load granted.
REQ-020 Continuous IFU and LSU reads, 10 transactions -> grants strictly alternate IFU/LSU after the first LSU grant.
REQ-021 rst in RD_R, then mem_rvalid=1 next cycle -> no rvalid pulse; outputs stay 0; state IDLE.
REQ-022 mem_arready low for 5 cycles -> mem_arvalid and mem_araddr stable throughout; no response before acceptance.

Source files
------------

// File: rtl/ysyx_bus_arb.sv
// Single-outstanding arbiter that merges the IFU fetch port and the LSU load/store
// ports onto one memory port, with round-robin between IFU and LSU.
module ysyx_bus_arb #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIT_W-1:0] ifu_araddr,
    input  logic             ifu_arvalid,
    output logic [BIT_W-1:0] ifu_rdata,
    output logic             ifu_rvalid,
    input  logic [BIT_W-1:0] lsu_araddr,
    input  logic             lsu_arvalid,
    input  logic [7:0]       lsu_rstrb,
    output logic [BIT_W-1:0] lsu_rdata,
    output logic             lsu_rvalid,
    input  logic [BIT_W-1:0] lsu_awaddr,
    input  logic             lsu_awvalid,
    input  logic [BIT_W-1:0] lsu_wdata,
    input  logic [7:0]       lsu_wstrb,
    input  logic             lsu_wvalid,
    output logic             lsu_wready,
    output logic [BIT_W-1:0] mem_araddr,
    output logic             mem_arvalid,
    output logic [7:0]       mem_rstrb,
    input  logic             mem_arready,
    input  logic [BIT_W-1:0] mem_rdata,
    input  logic             mem_rvalid,
    output logic [BIT_W-1:0] mem_awaddr,
    output logic             mem_awvalid,
    output logic [BIT_W-1:0] mem_wdata,
    output logic [7:0]       mem_wstrb,
    output logic             mem_wvalid,
    input  logic             mem_wready
);

    typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR, RESP} state_t;
    typedef enum logic [1:0] {OWN_IFU, OWN_LD, OWN_ST} owner_t;

    state_t           r_state;
    state_t           w_next;
    owner_t           r_owner;
    logic             r_last_lsu;
    logic [BIT_W-1:0] r_addr;
    logic [BIT_W-1:0] r_wdata;
    logic [BIT_W-1:0] r_rdata;
    logic [7:0]       r_strb;

    logic w_st_req;
    logic w_lsu_req;
    logic w_any_req;
    logic w_grant_lsu;

    assign w_st_req    = lsu_awvalid & lsu_wvalid;
    assign w_lsu_req   = w_st_req | lsu_arvalid;
    assign w_any_req   = w_lsu_req | ifu_arvalid;
    // On a tie the side that did not win last time gets the bus.
    assign w_grant_lsu = w_lsu_req & (~ifu_arvalid | ~r_last_lsu);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_lsu <= 1'b0;
            r_rdata    <= '0;
        end else begin
            // NOTE: every sequential assignment uses <= so all registers update from
            // the same pre-edge values regardless of statement order.
            r_state <= w_next;
            if (r_state == IDLE && w_any_req) begin
                r_last_lsu <= w_grant_lsu;
            end
            if (r_state == RD_R && mem_rvalid) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // NOTE: the request payload is left unreset; it is only observed in states that
    // are reached after it has been loaded, so a reset term would be dead logic.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_any_req) begin
            if (w_grant_lsu && w_st_req) begin
                r_owner <= OWN_ST;
                r_addr  <= lsu_awaddr;
                r_strb  <= lsu_wstrb;
                r_wdata <= lsu_wdata;
            end else if (w_grant_lsu) begin
                r_owner <= OWN_LD;
                r_addr  <= lsu_araddr;
                r_strb  <= lsu_rstrb;
            end else begin
                // Instruction fetches are always a full 32-bit word.
                r_owner <= OWN_IFU;
                r_addr  <= ifu_araddr;
                r_strb  <= 8'h0f;
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch forms.
        w_next      = r_state;
        mem_arvalid = 1'b0;
        mem_awvalid = 1'b0;
        mem_wvalid  = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_wready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_next = (w_grant_lsu && w_st_req) ? WR : RD_AR;
                end
            end
            RD_AR: begin
                mem_arvalid = 1'b1;
                if (mem_arready) w_next = RD_R;
            end
            RD_R: begin
                if (mem_rvalid) w_next = RESP;
            end
            WR: begin
                mem_awvalid = 1'b1;
                mem_wvalid  = 1'b1;
                if (mem_wready) w_next = RESP;
            end
            RESP: begin
                ifu_rvalid = (r_owner == OWN_IFU);
                lsu_rvalid = (r_owner == OWN_LD);
                lsu_wready = (r_owner == OWN_ST);
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign mem_araddr = r_addr;
    assign mem_awaddr = r_addr;
    assign mem_rstrb  = r_strb;
    assign mem_wstrb  = r_strb;
    assign mem_wdata  = r_wdata;
    assign ifu_rdata  = r_rdata;
    assign lsu_rdata  = r_rdata;

endmodule

// File: tb/tb_ysyx_bus_arb.sv
// Scoreboard bench for ysyx_bus_arb: requester agents and a memory model drive the
// DUT on the falling edge; expected responses are queued in predicted grant order.
module tb_ysyx_bus_arb;

    localparam int BIT_W = 32;
    localparam logic [1:0] K_IFU = 2'd0, K_LD = 2'd1, K_ST = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
        logic [7:0]  strb;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [BIT_W-1:0] ifu_araddr = '0, lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0;
    logic             ifu_arvalid = 1'b0, lsu_arvalid = 1'b0, lsu_awvalid = 1'b0, lsu_wvalid = 1'b0;
    logic [7:0]       lsu_rstrb = '0, lsu_wstrb = '0;
    logic [BIT_W-1:0] ifu_rdata, lsu_rdata, mem_araddr, mem_awaddr, mem_wdata;
    logic             ifu_rvalid, lsu_rvalid, lsu_wready, mem_arvalid, mem_awvalid, mem_wvalid;
    logic [7:0]       mem_rstrb, mem_wstrb;
    logic             mem_arready = 1'b0, mem_rvalid = 1'b0, mem_wready = 1'b0;
    logic [BIT_W-1:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];

    // agent / model knobs, written by tests only just after a rising edge
    int          ifu_todo = 0, ld_todo = 0, st_todo = 0;
    logic [31:0] ifu_addr = '0, ld_addr = '0, st_addr = '0, st_data = '0;
    logic [7:0]  ld_strb = '0, st_strb = '0;
    int          ar_delay = 0, r_delay = 0, w_delay = 0;
    logic        m_en = 1'b1, man_arready = 1'b0, man_rvalid = 1'b0;
    logic [31:0] man_rdata = '0;
    int          m_phase = 0, m_cnt = 0;
    logic [31:0] m_raddr = '0, m_waddr = '0, m_wdata = '0;
    logic [7:0]  m_rstrb = '0, m_wstrb = '0;

    ysyx_bus_arb #(.BIT_W(BIT_W)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_rstrb(mem_rstrb),
        .mem_arready(mem_arready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_awaddr(mem_awaddr), .mem_awvalid(mem_awvalid), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return {a[15:0], ~a[31:16]};
    endfunction

    // requester agents: hold the request until the response pulse, then advance
    always @(negedge clk) begin
        if (ifu_rvalid && ifu_todo > 0) begin ifu_todo--; ifu_addr += 4; end
        if (lsu_rvalid && ld_todo > 0)  begin ld_todo--;  ld_addr += 8; end
        if (lsu_wready && st_todo > 0)  begin st_todo--; end
        ifu_arvalid = (ifu_todo > 0);
        ifu_araddr  = ifu_addr;
        lsu_arvalid = (ld_todo > 0);
        lsu_araddr  = ld_addr;
        lsu_rstrb   = ld_strb;
        lsu_awvalid = (st_todo > 0);
        lsu_wvalid  = (st_todo > 0);
        lsu_awaddr  = st_addr;
        lsu_wdata   = st_data;
        lsu_wstrb   = st_strb;
    end

    // memory model with programmable handshake delays
    always @(negedge clk) begin
        if (!m_en) begin
            mem_arready = man_arready;
            mem_rvalid  = man_rvalid;
            mem_rdata   = man_rdata;
            mem_wready  = 1'b0;
            m_phase = 0;
            m_cnt   = 0;
        end else begin
            mem_arready = 1'b0;
            mem_rvalid  = 1'b0;
            mem_wready  = 1'b0;
            if (rst) begin
                m_phase = 0;
                m_cnt   = 0;
            end else if (m_phase == 1) begin
                if (m_cnt >= r_delay) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rd_data(m_raddr);
                    m_phase = 0;
                    m_cnt   = 0;
                end else m_cnt++;
            end else if (mem_arvalid) begin
                if (m_cnt >= ar_delay) begin
                    mem_arready = 1'b1;
                    m_raddr = mem_araddr;
                    m_rstrb = mem_rstrb;
                    m_phase = 1;
                    m_cnt   = 0;
                end else m_cnt++;
            end else if (mem_awvalid && mem_wvalid) begin
                if (m_cnt >= w_delay) begin
                    mem_wready = 1'b1;
                    m_waddr = mem_awaddr;
                    m_wdata = mem_wdata;
                    m_wstrb = mem_wstrb;
                    m_cnt   = 0;
                end else m_cnt++;
            end
        end
    end

    // response monitor: every pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (!rst && (ifu_rvalid || lsu_rvalid || lsu_wready)) begin
            n_vec++;
            if ($countones({ifu_rvalid, lsu_rvalid, lsu_wready}) != 1) begin
                n_err++;
                $display("FAIL resp_onehot: got ifu_rvalid=%b lsu_rvalid=%b lsu_wready=%b, need exactly one",
                         ifu_rvalid, lsu_rvalid, lsu_wready);
            end else if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL resp_unexpected: got pulse ifu=%b ld=%b st=%b, none expected",
                         ifu_rvalid, lsu_rvalid, lsu_wready);
            end else begin
                exp_t e;
                logic [1:0] k;
                logic ok;
                e = exp_q.pop_front();
                k = ifu_rvalid ? K_IFU : (lsu_rvalid ? K_LD : K_ST);
                ok = (k == e.kind);
                if (ok && k == K_IFU) ok = (ifu_rdata === e.data);
                if (ok && k == K_LD)  ok = (lsu_rdata === e.data) && (m_raddr === e.addr) && (m_rstrb === e.strb);
                if (ok && k == K_ST)  ok = (m_waddr === e.addr) && (m_wdata === e.data) && (m_wstrb === e.strb);
                if (!ok) begin
                    n_err++;
                    $display("FAIL resp_%0d: got kind=%0d ifu_rdata=%h lsu_rdata=%h rd_a=%h wr_a=%h wr_d=%h wr_s=%h, need kind=%0d addr=%h data=%h strb=%h",
                             e.kind, k, ifu_rdata, lsu_rdata, m_raddr, m_waddr, m_wdata, m_wstrb,
                             e.kind, e.addr, e.data, e.strb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] kind, input logic [31:0] addr,
                        input logic [31:0] data, input logic [7:0] strb);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = (kind == K_ST) ? data : rd_data(addr);
        e.strb = strb;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        ifu_todo = 0; ld_todo = 0; st_todo = 0;
        ar_delay = 0; r_delay = 0; w_delay = 0;
        m_en = 1'b1; man_arready = 1'b0; man_rvalid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        exp_q.delete();
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wait_done: got %0d responses outstanding after %0d cycles, need 0",
                     exp_q.size(), budget);
            exp_q.delete();
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_vec++;
        if ({ifu_rvalid, lsu_rvalid, lsu_wready, mem_arvalid, mem_awvalid, mem_wvalid} !== 6'b0 ||
            ifu_rdata !== 32'h0 || lsu_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: got valids=%b ifu_rdata=%h lsu_rdata=%h, need 0/0/0",
                     {ifu_rvalid, lsu_rvalid, lsu_wready, mem_arvalid, mem_awvalid, mem_wvalid},
                     ifu_rdata, lsu_rdata);
        end
        do_reset();
    endtask

    task automatic test_fetch_latency();
        do_reset();
        ifu_addr = 32'h8000_0000;
        ifu_todo = 1;
        push(K_IFU, 32'h8000_0000, 0, 8'h0f);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_vec++;
            if (mem_arvalid !== (c == 1) || ifu_rvalid !== (c == 3) ||
                (c == 1 && mem_araddr !== 32'h8000_0000) || (c == 3 && ifu_rdata !== 32'h0000_0413)) begin
                n_err++;
                $display("FAIL fetch_c%0d: got arvalid=%b araddr=%h rvalid=%b rdata=%h, need arvalid=%b rvalid=%b",
                         c, mem_arvalid, mem_araddr, ifu_rvalid, ifu_rdata, c == 1, c == 3);
            end
        end
        wait_done(20);
    endtask

    task automatic test_tie_lsu_first();
        do_reset();
        ifu_addr = 32'h8000_0010; ifu_todo = 1;
        ld_addr = 32'h0000_1000; ld_strb = 8'h0f; ld_todo = 1;
        push(K_LD, 32'h0000_1000, 0, 8'h0f);
        push(K_IFU, 32'h8000_0010, 0, 8'h0f);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h0000_1000) begin
            n_err++;
            $display("FAIL tie_first_addr: got arvalid=%b araddr=%h, need 1 00001000", mem_arvalid, mem_araddr);
        end
        wait_done(40);
    endtask

    task automatic test_store_then_load();
        do_reset();
        w_delay = 2;
        st_addr = 32'ha000_03f8; st_data = 32'h0000_0041; st_strb = 8'h01; st_todo = 1;
        ld_addr = 32'h0000_2000; ld_strb = 8'h03; ld_todo = 1;
        push(K_ST, 32'ha000_03f8, 32'h41, 8'h01);
        push(K_LD, 32'h0000_2000, 0, 8'h03);
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_vec++;
                if (mem_awvalid !== 1'b1 || mem_wvalid !== 1'b1 || mem_arvalid !== 1'b0 ||
                    mem_wstrb !== 8'h01 || mem_awaddr !== 32'ha000_03f8 || mem_wdata !== 32'h41) begin
                    n_err++;
                    $display("FAIL store_wr: got aw=%b w=%b ar=%b strb=%h addr=%h data=%h, need 1 1 0 01 a00003f8 00000041",
                             mem_awvalid, mem_wvalid, mem_arvalid, mem_wstrb, mem_awaddr, mem_wdata);
                end
            end
            if (c >= 3) begin
                n_vec++;
                if (lsu_wready !== (c == 4)) begin
                    n_err++;
                    $display("FAIL store_wready_c%0d: got %b, need %b", c, lsu_wready, c == 4);
                end
            end
        end
        wait_done(30);
    endtask

    task automatic test_back_to_back();
        do_reset();
        ifu_addr = 32'h8000_0200; ifu_todo = 5;
        ld_addr = 32'h0000_3000; ld_strb = 8'hff; ld_todo = 5;
        for (int i = 0; i < 5; i++) begin
            push(K_LD, 32'h0000_3000 + 32'(8 * i), 0, 8'hff);
            push(K_IFU, 32'h8000_0200 + 32'(4 * i), 0, 8'h0f);
        end
        wait_done(200);
    endtask

    task automatic test_drop_valid();
        do_reset();
        r_delay = 3;
        ifu_addr = 32'h8000_0100; ifu_todo = 1;
        push(K_IFU, 32'h8000_0100, 0, 8'h0f);
        tick();
        tick();
        ifu_todo = 0;
        wait_done(30);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (mem_arvalid !== 1'b0) begin
                n_err++;
                $display("FAIL drop_regrant_c%0d: got arvalid=%b, need 0", c, mem_arvalid);
            end
        end
    endtask

    task automatic test_rst_mid_read();
        do_reset();
        m_en = 1'b0;
        ifu_addr = 32'h8000_0300; ifu_todo = 1; man_arready = 1'b1;
        tick();
        tick();
        man_arready = 1'b0;
        ifu_todo = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        man_rvalid = 1'b1;
        man_rdata = 32'hdead_beef;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if ({ifu_rvalid, lsu_rvalid, lsu_wready, mem_arvalid, mem_awvalid} !== 5'b0 || ifu_rdata !== 32'h0) begin
                n_err++;
                $display("FAIL rst_mid_c%0d: got valids=%b ifu_rdata=%h, need 00000 00000000",
                         c, {ifu_rvalid, lsu_rvalid, lsu_wready, mem_arvalid, mem_awvalid}, ifu_rdata);
            end
            if (c == 0) begin
                #1;
                man_rvalid = 1'b0;
            end
        end
        m_en = 1'b1;
        tick();
    endtask

    task automatic test_arready_stall();
        do_reset();
        ar_delay = 5;
        ld_addr = 32'h0000_4440; ld_strb = 8'h0c; ld_todo = 1;
        push(K_LD, 32'h0000_4440, 0, 8'h0c);
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                n_vec++;
                if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h0000_4440 || mem_rstrb !== 8'h0c || lsu_rvalid !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_c%0d: got arvalid=%b araddr=%h rstrb=%h rvalid=%b, need 1 00004440 0c 0",
                             c, mem_arvalid, mem_araddr, mem_rstrb, lsu_rvalid);
                end
            end
        end
        wait_done(30);
    endtask

    initial begin
        test_reset();
        test_fetch_latency();
        test_tie_lsu_first();
        test_store_then_load();
        test_back_to_back();
        test_drop_valid();
        test_rst_mid_read();
        test_arready_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
